// File: rtl/mem_pkg.sv
// Shared types and helpers for the load/store unit: request length codes,
// FSM state encoding and the length-to-beat-count mapping.
package mem_pkg;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;
  localparam logic [1:0] LEN_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BEAT = 2'b01,
    RESP = 2'b10
  } state_t;

  function automatic logic [2:0] len_to_beats(input logic [1:0] len);
    case (len)
      LEN_HALF: return 3'd2;
      LEN_WORD: return 3'd4;
      default:  return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_rdata_fmt.sv
// Load result formatting: zero- or sign-extends the assembled little-endian
// bytes according to the access length.
module lsu_rdata_fmt
  import mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  len,
  input  logic        sgn,
  output logic [31:0] data
);

  always_comb begin
    case (len)
      LEN_BYTE: data = {{24{sgn & raw[7]}}, raw[7:0]};
      LEN_HALF: data = {{16{sgn & raw[15]}}, raw[15:0]};
      default:  data = raw;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator: serialises one 8/16/32-bit core request into byte
// beats on the RAM port. Define LSU_MISALIGN_EN to allow misaligned half/word.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int RAM_WIDTH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_len,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rw,
  output logic [1:0]  mem_len,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write,
  input  logic [31:0] mem_read,
  input  logic        mem_exception
);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  len_q, len_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  k_q, k_d;

  logic [2:0]  req_beats;
  logic [32:0] last_addr;
  logic        misalign;
  logic        pre_fail;
  logic        last_beat;
  logic        in_beat;
  logic [31:0] fmt_data;
  logic        unused_read_hi;

  assign unused_read_hi = ^mem_read[31:8];

  // Precheck works on the raw request so a failure can answer on cycle 1.
  assign req_beats = len_to_beats(req_len);
  assign last_addr = {1'b0, req_addr} + 33'(req_beats) - 33'd1;
`ifdef LSU_MISALIGN_EN
  assign misalign  = 1'b0;
`else
  assign misalign  = ((req_len == LEN_HALF) && req_addr[0]) ||
                     ((req_len == LEN_WORD) && (req_addr[1:0] != 2'b00));
`endif
  assign pre_fail  = (req_len == LEN_RSVD) || misalign || last_addr[32] ||
                     (|last_addr[31:RAM_WIDTH+1]);

  assign last_beat = (3'(k_q) == (len_to_beats(len_q) - 3'd1));

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    len_d    = len_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    k_d      = k_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          len_d    = req_len;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          k_d      = '0;
          err_d    = pre_fail;
          state_d  = pre_fail ? RESP : BEAT;
        end
      end
      BEAT: begin
        if (mem_exception) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          if (!we_q) rdata_d[8*k_q +: 8] = mem_read[7:0];
          if (last_beat) state_d = RESP;
          else           k_d     = k_q + 2'd1;
        end
      end
      RESP: begin
        k_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      len_q    <= LEN_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      len_q    <= len_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      k_q      <= k_d;
    end
  end

  lsu_rdata_fmt u_fmt (
    .raw  (rdata_q),
    .len  (len_q),
    .sgn  (signed_q),
    .data (fmt_data)
  );

  // Port drive is decoded from registered state so reset clears it at once.
  assign in_beat    = (state_q == BEAT);
  assign req_ready  = (state_q == IDLE);
  assign mem_rw     = in_beat & we_q & ~mem_exception;
  assign mem_len    = LEN_BYTE;
  assign mem_addr   = in_beat ? (addr_q + 32'(k_q)) : 32'd0;
  assign mem_write  = (in_beat & we_q) ? {24'd0, wdata_q[8*k_q +: 8]} : 32'd0;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = (resp_valid & ~err_q & ~we_q) ? fmt_data : 32'd0;

endmodule
